// File: rtl/cpu_types_pkg.sv
// Shared core types: hazard sequencer states
// and register index type.
package cpu_types_pkg;
  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hzc_state_t;

  typedef logic [REG_W_DEF-1:0] regbits_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;

  // next value: bump unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stall/enable/flush per latch,
// halt-drain FSM and stall/flush perf counters.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_halt,
  input  logic             mem_dreq,
  input  logic             dhit,
  input  logic             ihit,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  hzc_state_t state_q, state_d;
  logic       stall_inc, flush_inc;
  logic       freeze, load_use;

  assign freeze = mem_dreq && !dhit;

  // a load to x0 never produces a value to wait on
  assign load_use = ex_memread && (ex_rd != '0) &&
    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // latch controls and next state from priority rules
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    flush_inc   = 1'b0;
    if (!RST) begin
      unique case (state_q)
        RUN: begin
          if (freeze) begin
            pc_en = 1'b0;
          end else if (mem_halt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
            state_d     = DRAIN;
          end else if (ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!ihit) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          memwb_en = 1'b1;
          state_d  = HALTED;
        end
        HALTED: state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  assign stall_inc = !RST && (state_q == RUN) && !pc_en;
  assign halt_out  = (state_q == HALTED);

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_count)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit
// (narrow counters to reach saturation).
module tb_hazard_control_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [7:0] C_IDLE   = 8'b1101_0101;
  localparam logic [7:0] C_OFF    = 8'b0000_0000;
  localparam logic [7:0] C_LU     = 8'b0000_1101;
  localparam logic [7:0] C_BR     = 8'b1010_1101;
  localparam logic [7:0] C_MISS   = 8'b0011_0101;
  localparam logic [7:0] C_HALT   = 8'b0010_1011;
  localparam logic [7:0] C_DRAIN  = 8'b0000_0001;

  logic             CLK = 1'b0;
  logic             RST;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_memread, ex_branch_taken;
  logic             mem_halt, mem_dreq, dhit, ihit;
  logic             pc_en, ifid_en, ifid_flush;
  logic             idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en;
  logic             halt_out;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0]       ctl;

  int total_n = 0;
  int pass_n  = 0;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_halt        (mem_halt),
    .mem_dreq        (mem_dreq),
    .dhit            (dhit),
    .ihit            (ihit),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .exmem_flush     (exmem_flush),
    .memwb_en        (memwb_en),
    .halt_out        (halt_out),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_en, exmem_flush, memwb_en};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_halt = 1'b0; mem_dreq = 1'b0;
    dhit = 1'b0; ihit = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    tick();
    chk("rst_ctl", {24'd0, ctl}, {24'd0, C_OFF});
    RST = 1'b0;
    #1;
    chk("rst_stall", {28'd0, stall_cycles}, 32'd0);
    chk("rst_flush", {28'd0, flush_count}, 32'd0);
    chk("rst_halt", {31'd0, halt_out}, 32'd0);
    chk("idle_ctl", {24'd0, ctl}, {24'd0, C_IDLE});

    ex_memread = 1'b1; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    chk("x0_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    tick();
    chk("x0_stall", {28'd0, stall_cycles}, 32'd0);

    idle_inputs();
    ex_memread = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1;
    chk("lu_ctl", {24'd0, ctl}, {24'd0, C_LU});
    tick();
    ex_memread = 1'b0;
    #1;
    chk("lu_after_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    chk("lu_stall", {28'd0, stall_cycles}, 32'd1);

    idle_inputs();
    mem_dreq = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ctl", {24'd0, ctl}, {24'd0, C_OFF});
      tick();
    end
    chk("frz_flush_hold", {28'd0, flush_count}, 32'd0);
    dhit = 1'b1;
    #1;
    chk("frz_br_ctl", {24'd0, ctl}, {24'd0, C_BR});
    tick();
    chk("frz_flush", {28'd0, flush_count}, 32'd1);
    chk("frz_stall", {28'd0, stall_cycles}, 32'd4);

    idle_inputs();
    ex_branch_taken = 1'b1; ex_memread = 1'b1;
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    ihit = 1'b0;
    #1;
    chk("br_win_ctl", {24'd0, ctl}, {24'd0, C_BR});
    tick();
    chk("br_win_flush", {28'd0, flush_count}, 32'd2);
    chk("br_win_stall", {28'd0, stall_cycles}, 32'd4);

    idle_inputs();
    ihit = 1'b0;
    #1;
    chk("miss_ctl", {24'd0, ctl}, {24'd0, C_MISS});
    tick();
    chk("miss_stall", {28'd0, stall_cycles}, 32'd5);

    idle_inputs();
    mem_halt = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("halt_ctl", {24'd0, ctl}, {24'd0, C_HALT});
    tick();
    chk("halt_flush", {28'd0, flush_count}, 32'd2);
    chk("halt_stall", {28'd0, stall_cycles}, 32'd6);
    idle_inputs();
    ihit = 1'b0;
    #1;
    chk("drain_ctl", {24'd0, ctl}, {24'd0, C_DRAIN});
    chk("drain_halt", {31'd0, halt_out}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halted_out", {31'd0, halt_out}, 32'd1);
      chk("halted_ctl", {24'd0, ctl}, {24'd0, C_OFF});
      tick();
    end
    chk("halted_stall", {28'd0, stall_cycles}, 32'd6);
    chk("halted_flush", {28'd0, flush_count}, 32'd2);
    RST = 1'b1;
    #1;
    chk("halt_rst_ctl", {24'd0, ctl}, {24'd0, C_OFF});
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_halt", {31'd0, halt_out}, 32'd0);
    chk("post_rst_stall", {28'd0, stall_cycles}, 32'd0);
    chk("post_rst_flush", {28'd0, flush_count}, 32'd0);

    ihit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_reach", {28'd0, stall_cycles}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", {28'd0, stall_cycles}, 32'd15);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    idle_inputs();
    mem_dreq = 1'b1; dhit = 1'b0;
    tick();
    tick();
    chk("mfrz_stall", {28'd0, stall_cycles}, 32'd2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mem_dreq = 1'b0;
    #1;
    chk("mfrz_rst_ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    chk("mfrz_rst_stall", {28'd0, stall_cycles}, 32'd0);
    tick();
    chk("mfrz_no_resid", {28'd0, stall_cycles}, 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
